bus_interconnect: RTL and testbench

// Registered 2-master (ibus, dbus) to NUM_SLAVES interconnect for the VexRiscv SoC. It is the

---
 rtl/bus_interconnect.sv | 225 ++++++++++++++++++++++
 tb/tb_bus_interconnect.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : bus_interconnect
// Purpose  : Registered two-master (ibus, dbus) to NUM_SLAVES interconnect.
//            It uses a parameter-driven address map, fixed-priority or
//            round-robin arbitration, a grant that is held for the whole
//            transaction, and a per-transaction timeout that reports a hung
//            slave as an access fault.
// Revision : 1.0 - initial release
// ============================================================================
module bus_interconnect #(
    parameter int                       NUM_SLAVES     = 3,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = {32'h1000_0000, 32'h0200_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = {32'hFFFF_FF00, 32'hFF00_0000, 32'hFFC0_0000},
    parameter int                       ARB_MODE       = 0,
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // instruction master
    input  logic                       ibus_req,
    input  logic [31:0]                ibus_addr,
    output logic [31:0]                ibus_rdata,
    output logic                       ibus_ready,
    output logic                       ibus_error,
    // data master
    input  logic                       dbus_req,
    input  logic                       dbus_we,
    input  logic [31:0]                dbus_addr,
    input  logic [31:0]                dbus_wdata,
    input  logic [3:0]                 dbus_wstrb,
    output logic [31:0]                dbus_rdata,
    output logic                       dbus_ready,
    output logic                       dbus_error,
    // slave side
    output logic [NUM_SLAVES-1:0]      s_req,
    output logic                       s_we,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready
);

    localparam int C_SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // A disabled timeout still needs a one-bit counter so the vector is legal.
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_TO_LAST =
        (TIMEOUT_CYCLES > 0) ? C_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_ERR  = 2'd2;

    localparam logic C_M_IBUS = 1'b0;
    localparam logic C_M_DBUS = 1'b1;

    logic [1:0]         state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q,   cnt_d;
    logic               gnt_q,   gnt_d;
    logic [C_SEL_W-1:0] sel_q,   sel_d;

    logic               w_gnt_pick;
    logic [31:0]        w_pick_addr;
    logic               w_dec_hit;
    logic [C_SEL_W-1:0] w_dec_idx;
    logic               w_req_live;
    logic               w_sel_ready;
    logic [31:0]        w_sel_rdata;
    logic               w_timeout;

    // Arbitration: pick the master that would be granted if the FSM is idle.
    always_comb begin
        w_gnt_pick = C_M_IBUS;
        if (dbus_req && ibus_req) begin
            if (ARB_MODE == 0) begin
                w_gnt_pick = C_M_DBUS;
            end else begin
                w_gnt_pick = ~gnt_q;
            end
        end else if (dbus_req) begin
            w_gnt_pick = C_M_DBUS;
        end
        w_pick_addr = (w_gnt_pick == C_M_DBUS) ? dbus_addr : ibus_addr;
    end

    // Address decode: scan downwards so the lowest matching index wins.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((w_pick_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                w_dec_hit = 1'b1;
                w_dec_idx = C_SEL_W'(i);
            end
        end
    end

    // Select the ready/rdata of the latched slave; other slaves are ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == C_SEL_W'(i)) begin
                w_sel_ready = s_ready[i];
                w_sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    // Live request of the granted master and the timeout condition.
    always_comb begin
        w_req_live = (gnt_q == C_M_DBUS) ? dbus_req : ibus_req;
        w_timeout  = (TIMEOUT_CYCLES > 0) && (cnt_q == C_TO_LAST);
    end

    // State register: FSM state, busy counter, grant and slave select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= C_M_IBUS;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for slave/timeout/abort in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            C_ST_IDLE: begin
                if (ibus_req || dbus_req) begin
                    gnt_d   = w_gnt_pick;
                    sel_d   = w_dec_idx;
                    cnt_d   = '0;
                    state_d = w_dec_hit ? C_ST_BUSY : C_ST_ERR;
                end
            end
            C_ST_BUSY: begin
                if (!w_req_live || w_sel_ready || w_timeout) begin
                    state_d = C_ST_IDLE;
                end else if (cnt_q != C_CNT_MAX) begin
                    // Saturating so a disabled timeout never wraps the count.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_ST_ERR: begin
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // Output logic: slave-side broadcast in BUSY and response routing.
    always_comb begin
        s_req      = '0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        ibus_ready = 1'b0;
        ibus_error = 1'b0;
        ibus_rdata = '0;
        dbus_ready = 1'b0;
        dbus_error = 1'b0;
        dbus_rdata = '0;
        case (state_q)
            C_ST_BUSY: begin
                // A dropped request aborts silently: no slave request, no response.
                if (w_req_live) begin
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        s_req[i] = (sel_q == C_SEL_W'(i));
                    end
                    if (gnt_q == C_M_DBUS) begin
                        s_we    = dbus_we;
                        s_addr  = dbus_addr;
                        s_wdata = dbus_wdata;
                        s_wstrb = dbus_wstrb;
                        if (w_sel_ready) begin
                            dbus_ready = 1'b1;
                            dbus_rdata = w_sel_rdata;
                        end else if (w_timeout) begin
                            dbus_ready = 1'b1;
                            dbus_error = 1'b1;
                        end
                    end else begin
                        s_addr  = ibus_addr;
                        s_wstrb = 4'hF;
                        if (w_sel_ready) begin
                            ibus_ready = 1'b1;
                            ibus_rdata = w_sel_rdata;
                        end else if (w_timeout) begin
                            ibus_ready = 1'b1;
                            ibus_error = 1'b1;
                        end
                    end
                end
            end
            C_ST_ERR: begin
                if (gnt_q == C_M_DBUS) begin
                    dbus_ready = 1'b1;
                    dbus_error = 1'b1;
                end else begin
                    ibus_ready = 1'b1;
                    ibus_error = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_interconnect
// Purpose  : Directed self-checking bench for bus_interconnect. Two instances
//            share all inputs: dut_rr (round-robin, TIMEOUT_CYCLES = 4) and
//            dut_fp (fixed priority, TIMEOUT_CYCLES = 255).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect;

    logic        clk;
    logic        rst_n;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic [95:0] s_rdata;
    logic [2:0]  s_ready;

    logic [31:0] ibus_rdata_rr, dbus_rdata_rr, s_addr_rr, s_wdata_rr;
    logic        ibus_ready_rr, ibus_error_rr, dbus_ready_rr, dbus_error_rr, s_we_rr;
    logic [2:0]  s_req_rr;
    logic [3:0]  s_wstrb_rr;

    logic [31:0] ibus_rdata_fp, dbus_rdata_fp, s_addr_fp, s_wdata_fp;
    logic        ibus_ready_fp, ibus_error_fp, dbus_ready_fp, dbus_error_fp, s_we_fp;
    logic [2:0]  s_req_fp;
    logic [3:0]  s_wstrb_fp;

    int n_vec  = 0;
    int n_miss = 0;

    bus_interconnect #(.ARB_MODE(1), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_rdata(ibus_rdata_rr), .ibus_ready(ibus_ready_rr), .ibus_error(ibus_error_rr),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_rdata(dbus_rdata_rr), .dbus_ready(dbus_ready_rr), .dbus_error(dbus_error_rr),
        .s_req(s_req_rr), .s_we(s_we_rr), .s_addr(s_addr_rr), .s_wdata(s_wdata_rr),
        .s_wstrb(s_wstrb_rr), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    bus_interconnect #(.ARB_MODE(0), .TIMEOUT_CYCLES(255)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_rdata(ibus_rdata_fp), .ibus_ready(ibus_ready_fp), .ibus_error(ibus_error_fp),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_rdata(dbus_rdata_fp), .dbus_ready(dbus_ready_fp), .dbus_error(dbus_error_fp),
        .s_req(s_req_fp), .s_we(s_we_fp), .s_addr(s_addr_fp), .s_wdata(s_wdata_fp),
        .s_wstrb(s_wstrb_fp), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] exp_rr [6];
    logic [1:0] exp_fp [6];

    initial begin
        exp_rr = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        exp_fp = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

        rst_n      = 1'b0;
        ibus_req   = 1'b0;
        ibus_addr  = '0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_wdata = '0;
        dbus_wstrb = '0;
        s_ready    = '0;
        s_rdata    = {32'h5555_0002, 32'h7777_0001, 32'hDEAD_BEEF};

        // ---------------- reset state ----------------
        cyc(); cyc(); settle();
        check_eq("rst_sreq_rr",  32'(s_req_rr), 32'h0);
        check_eq("rst_sreq_fp",  32'(s_req_fp), 32'h0);
        check_eq("rst_ready_rr", 32'({ibus_ready_rr, dbus_ready_rr, ibus_error_rr, dbus_error_rr}), 32'h0);
        check_eq("rst_bcast_rr", s_addr_rr | s_wdata_rr | 32'(s_wstrb_rr) | 32'(s_we_rr), 32'h0);
        cyc(); rst_n = 1'b1;

        // ---------------- arbitration: both masters request continuously ----------------
        cyc();
        ibus_req = 1'b1; ibus_addr = 32'h0000_0000;
        dbus_req = 1'b1; dbus_addr = 32'h0000_0004; dbus_we = 1'b0;
        s_ready  = 3'b001;
        settle();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                cyc(); settle();
            end
            check_eq($sformatf("arb_rr_c%0d", k), 32'({ibus_ready_rr, dbus_ready_rr}), 32'(exp_rr[k]));
            check_eq($sformatf("arb_fp_c%0d", k), 32'({ibus_ready_fp, dbus_ready_fp}), 32'(exp_fp[k]));
        end
        cyc();
        ibus_req = 1'b0; dbus_req = 1'b0; s_ready = '0;
        settle();
        check_eq("arb_end_sreq_rr", 32'(s_req_rr), 32'h0);

        // ---------------- ibus fetch, RAM 3 wait cycles ----------------
        cyc();
        ibus_req = 1'b1; ibus_addr = 32'h0000_0100;
        settle();
        check_eq("if_grant_sreq", 32'(s_req_rr), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); settle();
            check_eq($sformatf("if_sreq_c%0d", k), 32'(s_req_rr), 32'h1);
            check_eq($sformatf("if_rdy_c%0d", k), 32'(ibus_ready_rr), 32'h0);
        end
        check_eq("if_wstrb", 32'(s_wstrb_rr), 32'hF);
        check_eq("if_saddr", s_addr_rr, 32'h0000_0100);
        cyc(); s_ready = 3'b001; settle();
        check_eq("if_ready_rr", 32'({ibus_ready_rr, ibus_error_rr, dbus_ready_rr}), 32'b100);
        check_eq("if_ready_fp", 32'({ibus_ready_fp, ibus_error_fp, dbus_ready_fp}), 32'b100);
        check_eq("if_rdata", ibus_rdata_rr, 32'hDEAD_BEEF);
        cyc(); ibus_req = 1'b0; s_ready = '0; settle();
        check_eq("if_after", 32'({ibus_ready_rr, s_req_rr}), 32'h0);

        // ---------------- dbus write to UART, zero wait ----------------
        cyc();
        dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h1000_0004;
        dbus_wdata = 32'h0000_00A5; dbus_wstrb = 4'b0001;
        settle();
        check_eq("wr_grant_sreq", 32'(s_req_fp), 32'h0);
        cyc(); s_ready = 3'b100; settle();
        check_eq("wr_sreq", 32'(s_req_fp), 32'b100);
        check_eq("wr_we", 32'(s_we_fp), 32'h1);
        check_eq("wr_wdata", s_wdata_fp, 32'h0000_00A5);
        check_eq("wr_wstrb", 32'(s_wstrb_fp), 32'h1);
        check_eq("wr_ready", 32'({dbus_ready_rr, dbus_error_rr, dbus_ready_fp, dbus_error_fp}), 32'b1010);
        cyc(); dbus_req = 1'b0; dbus_we = 1'b0; s_ready = '0; settle();
        check_eq("wr_after", 32'({dbus_ready_fp, s_req_fp}), 32'h0);

        // ---------------- dbus read, unmapped address ----------------
        cyc(); dbus_req = 1'b1; dbus_addr = 32'h2000_0000; settle();
        check_eq("um_grant", 32'({dbus_ready_rr, s_req_rr}), 32'h0);
        cyc(); settle();
        check_eq("um_sreq", 32'({s_req_rr, s_req_fp}), 32'h0);
        check_eq("um_resp_rr", 32'({dbus_ready_rr, dbus_error_rr}), 32'b11);
        check_eq("um_resp_fp", 32'({dbus_ready_fp, dbus_error_fp}), 32'b11);
        check_eq("um_rdata", dbus_rdata_rr, 32'h0);
        cyc(); dbus_req = 1'b0; settle();
        check_eq("um_after", 32'({dbus_ready_rr, dbus_error_rr}), 32'h0);

        // ---------------- timeout on the timer slave ----------------
        cyc(); dbus_req = 1'b1; dbus_addr = 32'h0200_0010; settle();
        for (int k = 1; k <= 3; k++) begin
            cyc(); settle();
            check_eq($sformatf("to_sreq_c%0d", k), 32'(s_req_rr), 32'b010);
            check_eq($sformatf("to_rdy_c%0d", k), 32'(dbus_ready_rr), 32'h0);
        end
        cyc(); settle();
        check_eq("to_fault", 32'({dbus_ready_rr, dbus_error_rr}), 32'b11);
        check_eq("to_rdata", dbus_rdata_rr, 32'h0);
        check_eq("to_fp_wait", 32'({dbus_ready_fp, s_req_fp}), 32'b0010);
        // Request held with a new address: next transaction goes to RAM.
        cyc(); dbus_addr = 32'h0000_0040; settle();
        check_eq("to_sreq_drop", 32'({dbus_ready_rr, s_req_rr}), 32'h0);
        cyc(); s_ready = 3'b001; settle();
        check_eq("to_next_sreq", 32'(s_req_rr), 32'b001);
        check_eq("to_next_resp", 32'({dbus_ready_rr, dbus_error_rr}), 32'b10);
        check_eq("to_next_rdata", dbus_rdata_rr, 32'hDEAD_BEEF);
        check_eq("fp_unsel_ignored", 32'({dbus_ready_fp, s_req_fp}), 32'b0010);
        // fp master abandons its hung transaction.
        cyc(); dbus_req = 1'b0; s_ready = '0; settle();
        check_eq("abort_sreq", 32'({dbus_ready_fp, s_req_fp}), 32'h0);
        cyc(); settle();
        check_eq("abort_idle", 32'({dbus_ready_fp, dbus_error_fp, s_req_fp}), 32'h0);

        // ---------------- reset while BUSY ----------------
        cyc(); ibus_req = 1'b1; ibus_addr = 32'h0000_0100; settle();
        cyc(); settle();
        check_eq("rb_busy", 32'({s_req_rr, s_req_fp}), 32'b001001);
        cyc(); rst_n = 1'b0; ibus_req = 1'b0; s_ready = 3'b001; settle();
        check_eq("rb_sreq", 32'({s_req_rr, s_req_fp}), 32'h0);
        check_eq("rb_ready", 32'({ibus_ready_rr, ibus_ready_fp}), 32'h0);
        cyc(); rst_n = 1'b1; settle();
        check_eq("rb_release", 32'({ibus_ready_rr, ibus_ready_fp, s_req_rr}), 32'h0);
        cyc(); settle();
        check_eq("rb_idle", 32'({ibus_ready_fp, s_req_fp, s_req_rr}), 32'h0);
        s_ready = '0;

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
